// File: rtl/conv3x3_pkg.sv
// Shared types and constants for the 3x3 streaming window filter.
package conv3x3_pkg;

  typedef enum logic [1:0] {
    MODE_GAUSS   = 2'd0,
    MODE_SOBEL_H = 2'd1,
    MODE_SOBEL_V = 2'd2,
    MODE_DENOISE = 2'd3
  } mode_e;

  // Width of the default 4-bit pixel variant of the engine.
  localparam int PIX_W_DEFAULT = 4;

  // Gaussian blur weights, row-major with row 0 at the top.
  localparam int GAUSS_K [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

  // The weighted sum of GAUSS_K is 16, so the normalising shift is 4.
  localparam int GAUSS_SHIFT = 4;

  // Sobel smoothing weights along the edge direction.
  localparam int SOBEL_K [3] = '{1, 2, 1};

  // 3x3 window of default-width pixels: [row][col][bit], [0][0] is top-left.
  typedef logic [2:0][2:0][PIX_W_DEFAULT-1:0] window_t;

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel stream, result stream and per-frame kernel controls of conv3x3_stream.
interface conv3x3_stream_if #(
  parameter int PIX_W = 4,
  parameter int OUT_W = 16
);
  logic [1:0]       mode;
  logic [3:0]       thresh;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_pix;
  logic             out_last;

  // The pixel source and result sink side.
  modport master (
    output mode, thresh, in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_pix, out_last
  );

  // The filter engine side.
  modport slave (
    input  mode, thresh, in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_pix, out_last
  );
endinterface

// File: rtl/conv3x3_linebuf.sv
// Two line memories holding the previous two image lines, read and written at
// the current column on every accepted pixel.
module conv3x3_linebuf #(
  parameter int PIX_W = 4,
  parameter int IMG_W = 64,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [CW-1:0]    col_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] prev1_o,
  output logic [PIX_W-1:0] prev2_o
);

  logic [PIX_W-1:0] line1_q [IMG_W];
  logic [PIX_W-1:0] line2_q [IMG_W];

  assign prev1_o = line1_q[col_i];
  assign prev2_o = line2_q[col_i];

  // On accept the line above moves up one slot and the new pixel takes its place.
  always_ff @(posedge clk) begin
    if (en_i) begin
      line2_q[col_i] <= line1_q[col_i];
      line1_q[col_i] <= pix_i;
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 window filter: raster pixels in, one kernel result per full
// window out, with a global stall driven by the output register.
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int PIX_W = 4,
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int OUT_W = 16
) (
  input logic clk,
  input logic rst,
  conv3x3_stream_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = PIX_W + 4;

  logic             advance;
  logic             accept;
  logic             frameStart;
  logic             winValid;
  logic             winLast;

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  mode_e            mode_q, mode_d;
  logic [3:0]       thresh_q, thresh_d;

  logic [PIX_W-1:0] prev1;
  logic [PIX_W-1:0] prev2;
  logic [2:0][PIX_W-1:0] curCol;
  logic [2:0][PIX_W-1:0] colM1_q;
  logic [2:0][PIX_W-1:0] colM2_q;
  logic [2:0][2:0][PIX_W-1:0] win;

  logic [SW-1:0]    partA_d, partB_d, partC_d;
  logic [SW-1:0]    partA_q, partB_q, partC_q;
  logic             s1Valid_q;
  logic             s1Last_q;
  mode_e            s1Mode_q;
  logic [3:0]       s1Thresh_q;

  logic [SW-1:0]           gaussSum;
  logic signed [OUT_W-1:0] sobelDiff;
  logic [OUT_W-1:0]        outPix_d;
  logic                    outValid_q;
  logic [OUT_W-1:0]        outPix_q;
  logic                    outLast_q;

  assign advance      = !outValid_q || bus.out_ready;
  assign accept       = bus.in_valid && advance;
  assign bus.in_ready = advance;
  assign bus.out_valid = outValid_q;
  assign bus.out_pix   = outPix_q;
  assign bus.out_last  = outLast_q;

  assign frameStart = accept && (col_q == '0) && (row_q == '0);
  assign winValid   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign winLast    = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));

  conv3x3_linebuf #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .CW    (CW)
  ) u_linebuf (
    .clk     (clk),
    .en_i    (accept),
    .col_i   (col_q),
    .pix_i   (bus.in_pix),
    .prev1_o (prev1),
    .prev2_o (prev2)
  );

  // Raster position advances per accepted pixel and wraps at line and frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Kernel controls are captured with the first pixel of a frame only.
  always_comb begin
    mode_d   = mode_q;
    thresh_d = thresh_q;
    if (frameStart) begin
      mode_d   = mode_e'(bus.mode);
      thresh_d = bus.thresh;
    end
  end

  // Position counters and the per-frame kernel controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= MODE_GAUSS;
      thresh_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      mode_q   <= mode_d;
      thresh_q <= thresh_d;
    end
  end

  // Current column is the two stored lines above plus the incoming pixel.
  always_comb begin
    curCol[0] = prev2;
    curCol[1] = prev1;
    curCol[2] = bus.in_pix;
    for (int r = 0; r < 3; r++) begin
      win[r][0] = colM2_q[r];
      win[r][1] = colM1_q[r];
      win[r][2] = curCol[r];
    end
  end

  // The two older window columns shift left on every accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      colM2_q <= colM1_q;
      colM1_q <= curCol;
    end
  end

  // Stage 1 reduces the window to at most three partial sums for the kernel.
  always_comb begin
    partA_d = '0;
    partB_d = '0;
    partC_d = '0;
    case (mode_q)
      MODE_GAUSS: begin
        for (int c = 0; c < 3; c++) begin
          partA_d = partA_d + SW'(GAUSS_K[0][c]) * SW'(win[0][c]);
          partB_d = partB_d + SW'(GAUSS_K[1][c]) * SW'(win[1][c]);
          partC_d = partC_d + SW'(GAUSS_K[2][c]) * SW'(win[2][c]);
        end
      end
      MODE_SOBEL_H: begin
        for (int r = 0; r < 3; r++) begin
          partA_d = partA_d + SW'(SOBEL_K[r]) * SW'(win[r][2]);
          partB_d = partB_d + SW'(SOBEL_K[r]) * SW'(win[r][0]);
        end
      end
      MODE_SOBEL_V: begin
        for (int c = 0; c < 3; c++) begin
          partA_d = partA_d + SW'(SOBEL_K[c]) * SW'(win[2][c]);
          partB_d = partB_d + SW'(SOBEL_K[c]) * SW'(win[0][c]);
        end
      end
      MODE_DENOISE: begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            if (!(r == 1 && c == 1)) begin
              partA_d = partA_d + SW'(win[r][c][0]);
            end
          end
        end
        partC_d = SW'(win[1][1][0]);
      end
      default: begin
        partA_d = '0;
      end
    endcase
  end

  // Stage 1 register; mode and threshold travel with the data so a new frame
  // starting behind the last window cannot change how that window finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Last_q   <= 1'b0;
      s1Mode_q   <= MODE_GAUSS;
      s1Thresh_q <= '0;
      partA_q    <= '0;
      partB_q    <= '0;
      partC_q    <= '0;
    end else if (advance) begin
      s1Valid_q  <= winValid;
      s1Last_q   <= winLast;
      s1Mode_q   <= mode_q;
      s1Thresh_q <= thresh_q;
      partA_q    <= partA_d;
      partB_q    <= partB_d;
      partC_q    <= partC_d;
    end
  end

  // Stage 2 combines the partial sums and formats the result for its mode.
  always_comb begin
    gaussSum  = partA_q + partB_q + partC_q;
    sobelDiff = signed'(OUT_W'(partA_q)) - signed'(OUT_W'(partB_q));
    outPix_d  = '0;
    case (s1Mode_q)
      MODE_GAUSS:   outPix_d = OUT_W'(gaussSum >> GAUSS_SHIFT);
      MODE_SOBEL_H: outPix_d = sobelDiff;
      MODE_SOBEL_V: outPix_d = sobelDiff;
      MODE_DENOISE: outPix_d = OUT_W'((partA_q >= SW'(s1Thresh_q)) && partC_q[0]);
      default:      outPix_d = '0;
    endcase
  end

  // Output register holds its contents while the consumer is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outPix_q   <= '0;
      outLast_q  <= 1'b0;
    end else if (advance) begin
      outValid_q <= s1Valid_q;
      outLast_q  <= s1Valid_q && s1Last_q;
      if (s1Valid_q) begin
        outPix_q <= outPix_d;
      end
    end
  end

endmodule
